// File: rtl/tlb_query.sv
// TLBR/TLBP engine: reads one TLB entry back into the CP0 images, or scans all
// entries for the current VPN2/ASID and produces the CP0 Index value.
module tlb_query #(
   parameter int NUM_ENTRIES = 16,
   parameter int IDX_W       = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op_probe,
   input  logic             flush,
   input  logic [31:0]      index_i,
   input  logic [31:0]      entryhi_i,
   output logic [IDX_W-1:0] entry_addr,
   input  logic [95:0]      entry_data,
   output logic             busy,
   output logic             done,
   output logic             index_we,
   output logic [31:0]      index_o,
   output logic             entry_we,
   output logic [31:0]      entryhi_o,
   output logic [31:0]      entrylo0_o,
   output logic [31:0]      entrylo1_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      SCAN = 2'd2,
      FIN  = 2'd3
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

   state_t           state;
   logic [IDX_W-1:0] cnt;
   logic [18:0]      vpn2_q;
   logic [7:0]       asid_q;
   logic             done_q;
   logic             index_we_q;
   logic             entry_we_q;
   logic             match;

   // Valid/global bits are deliberately not part of the probe compare.
   assign match = (entry_data[95:77] == vpn2_q) && (entry_data[71:64] == asid_q);

   assign entry_addr = cnt;
   assign busy       = (state != IDLE);
   // A flush landing in FIN kills the pulses already queued for that cycle.
   assign done       = done_q & ~flush;
   assign index_we   = index_we_q & ~flush;
   assign entry_we   = entry_we_q & ~flush;

   logic unused_bits;
   assign unused_bits = &{1'b0, index_i[31:IDX_W], entryhi_i[12:8], entry_data[76:72]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         vpn2_q     <= '0;
         asid_q     <= '0;
         done_q     <= 1'b0;
         index_we_q <= 1'b0;
         entry_we_q <= 1'b0;
         index_o    <= '0;
         entryhi_o  <= '0;
         entrylo0_o <= '0;
         entrylo1_o <= '0;
      end else begin
         done_q     <= 1'b0;
         index_we_q <= 1'b0;
         entry_we_q <= 1'b0;
         if (flush) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (op_probe) begin
                        vpn2_q <= entryhi_i[31:13];
                        asid_q <= entryhi_i[7:0];
                        cnt    <= '0;
                        state  <= SCAN;
                     end else begin
                        cnt   <= index_i[IDX_W-1:0];
                        state <= READ;
                     end
                  end
               end
               READ: begin
                  entryhi_o  <= entry_data[95:64];
                  entrylo0_o <= entry_data[63:32];
                  entrylo1_o <= entry_data[31:0];
                  done_q     <= 1'b1;
                  entry_we_q <= 1'b1;
                  state      <= FIN;
               end
               SCAN: begin
                  if (match) begin
                     index_o    <= {{(32 - IDX_W){1'b0}}, cnt};
                     done_q     <= 1'b1;
                     index_we_q <= 1'b1;
                     state      <= FIN;
                  end else if (cnt == LAST_IDX) begin
                     index_o    <= 32'h8000_0000;
                     done_q     <= 1'b1;
                     index_we_q <= 1'b1;
                     state      <= FIN;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               FIN: state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
